bytes2bits_gearbox: RTL and testbench
=====================================

# bytes2bits_gearbox

Streaming, parametrised successor to the combinational `bytes2bits` converter. It accepts byte beats over a valid/ready handshake and re-slices the little-endian (LSB-first) bit stream into `OUT_BITS`-wide words, also over valid/ready. It sits in front of the ByteDecode/decompression datapath, where coefficients are `d` bits wide and do not align to byte boundaries. A final partial word is zero-padded and tagged last.

## Interface
- `IN_BYTES`, 4: bytes per input beat; `IN_W = 8*IN_BYTES`.
- `OUT_BITS`, 12: output word width, 1..32.
- `clk` input, 1: sole clock.
- `rst` input, 1: asynchronous, active-high reset.
- `in_valid` input, 1: input beat valid.
- `in_ready` output, 1: gearbox can accept a beat.
- `in_bytes` input, `[IN_BYTES-1:0][7:0]`: byte 0 is first in the stream, bit 0 of each byte is first.
- `in_nbytes` input, `$clog2(IN_BYTES+1)`: valid bytes in the beat, 1..IN_BYTES, counted from byte 0. Other bytes are ignored.
- `in_last` input, 1: final beat of the stream.
- `out_valid` output, 1: output word valid.
- `out_ready` input, 1: downstream accepts the word.
- `out_data` output, `OUT_BITS`: next `OUT_BITS` stream bits, first bit at bit 0.
- `out_last` output, 1: final word of the stream.

## Operation
- State: `buf` (`BUF_W = IN_W + 2*OUT_BITS - 1` bits), `cnt` (valid bits in `buf`, 0..BUF_W), FSM `{STREAM, DRAIN}`.
- Reset values: `buf=0`, `cnt=0`, FSM=STREAM, `out_valid=0`, `out_last=0`, `out_data=0`. `in_ready` is forced to 0 while `rst` is high.
- `in_ready = (state==STREAM) && (cnt < 2*OUT_BITS)`. It depends only on registered state and has no combinational path from `out_ready`.
- `out_valid = (cnt >= OUT_BITS) || (state==DRAIN && cnt > 0)`.
- `out_data = buf[OUT_BITS-1:0]`. Bits at positions ≥ `cnt` are always 0, because `buf` is zero above `cnt` by invariant.
- `out_last = out_valid && state==DRAIN && cnt <= OUT_BITS`.
- Output fire (`out_valid && out_ready`):
  - Consume `k = min(cnt, OUT_BITS)` bits.
  - Shift `buf` right by `k` and zero-fill.
- Input fire (`in_valid && in_ready`):
  - Append `8*in_nbytes` bits at position `cnt - k`, where `k=0` if there is no output fire.
  - Unused bytes are masked to 0 before the append.
- Simultaneous fires in one cycle: `cnt_next = cnt - k + 8*in_nbytes`. Both fires happen in the same cycle.
- Capacity: `cnt < 2*OUT_BITS` at accept, so `cnt_next ≤ BUF_W`. Overflow is impossible by construction.
- FSM transitions:
  - STREAM → DRAIN on an accepted beat with `in_last=1`.
  - DRAIN → STREAM on an output fire with `out_last=1`. `cnt` becomes 0.
  - In DRAIN, `in_ready=0`.
- Empty stream: a stream always carries at least 1 byte, since `in_nbytes ≥ 1`. A zero-length stream is not representable.
- Out-of-range `in_nbytes` (0 or > IN_BYTES) is illegal. It is flagged by an assertion, not by RTL recovery.

## Timing
- Latency: a beat accepted at edge *n* gives `out_valid` high after edge *n*, if `cnt_next ≥ OUT_BITS` or the beat was last.
- Throughput: one output word per cycle is sustained whenever input is offered at least as fast as `OUT_BITS/IN_W` beats per cycle.
- Back-to-back streams: the first beat of the next stream is accepted the cycle after the `out_last` fire.
- Valid rules:
  - `out_valid`/`out_data`/`out_last` stay stable while `out_valid && !out_ready`.
  - Upstream must hold `in_*` stable while `in_valid && !in_ready`.
- Reset mid-stream: all buffered bits and any pending last are discarded immediately. No output is emitted for the aborted stream.

## Structure
- Package `conv_pkg`:
  - `localparam` helper functions `buf_w(IN_BYTES, OUT_BITS)` and `cnt_w(...)`.
  - `typedef enum logic {STREAM, DRAIN} b2b_state_e`.
- One module, no sub-module. Shift, mask and append are single combinational blocks feeding the `buf`/`cnt`/state registers.
- SVA, bound in the bench:
  - `cnt ≤ BUF_W`.
  - `buf` is zero above `cnt`.
  - Output stability under stall.
  - `in_nbytes` is in range.

## Test plan
- Single beat, IN_BYTES=4, OUT_BITS=12: bytes EF,CD,AB,89, `in_nbytes=4`, `in_last=1`, `out_ready=1`. Expect three words in order:
  - 0xDEF
  - 0xABC
  - 0x089 with `out_last=1`
- Exact fit: three beats, bytes 00..0B, last on the third beat, giving 96 bits. Expect 8 words:
  - first two words are 0x100 and 0x020
  - `out_last` only on word 8
  - no padded word
- Backpressure: `out_ready=0` for 10 cycles during a 4-beat stream. Expect:
  - `in_ready` drops once `cnt ≥ 24`
  - outputs stay stable during the stall
  - the stream is bit-exact versus the reference model afterwards
- Partial last beat: a single beat with `in_nbytes=1`, byte0=0xFF, bytes1..3=0xAA. Expect one word 0x0FF with `out_last=1`; the 0xAA bytes never appear.
- Reset mid-stream: assert `rst` while `cnt=20`. Expect:
  - `out_valid=0` and `in_ready=0` during reset
  - after release, a new stream EF,CD,AB,89 reproduces the words 0xDEF, 0xABC, 0x089 exactly
- Parameter sweep: OUT_BITS ∈ {1, 8, 13} on random streams against the scoreboard. With OUT_BITS=8, expect `out_data` to equal the input bytes in order, matching the `bytes2bits` mapping.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared state type and sizing helpers for the byte-to-bit gearbox.
package conv_pkg;

    typedef enum logic {
        STREAM = 1'b0,
        DRAIN  = 1'b1
    } b2b_state_e;

    function automatic int buf_w(input int in_bytes, input int out_bits);
        return 8 * in_bytes + 2 * out_bits - 1;
    endfunction

    function automatic int cnt_w(input int in_bytes, input int out_bits);
        return $clog2(buf_w(in_bytes, out_bits) + 1);
    endfunction

endpackage

// File: rtl/bytes2bits_gearbox.sv
// Streaming gearbox: LSB-first byte beats re-sliced into OUT_BITS-wide words.
// A final partial word is zero-padded and tagged last.
module bytes2bits_gearbox
    import conv_pkg::*;
#(
    parameter int IN_BYTES = 4,
    parameter int OUT_BITS = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_BYTES-1:0][7:0]      in_bytes,
    input  logic [$clog2(IN_BYTES+1)-1:0] in_nbytes,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_BITS-1:0]           out_data,
    output logic                          out_last
);

    localparam int IN_W  = 8 * IN_BYTES;
    localparam int BUF_W = buf_w(IN_BYTES, OUT_BITS);
    localparam int CNT_W = cnt_w(IN_BYTES, OUT_BITS);

    localparam logic [CNT_W-1:0] OUT_CNT  = CNT_W'(OUT_BITS);
    localparam logic [CNT_W-1:0] HIGH_CNT = CNT_W'(2 * OUT_BITS);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    b2b_state_e       state_q, state_d;

    logic             in_fire;
    logic             out_fire;
    logic [CNT_W-1:0] take;
    logic [CNT_W-1:0] cnt_kept;
    logic [CNT_W-1:0] in_bits;
    logic [BUF_W-1:0] buf_kept;
    logic [BUF_W-1:0] append;
    logic [IN_W-1:0]  in_masked;

    // Handshake outputs come from registered state only; rst gates in_ready directly.
    assign in_ready  = !rst && (state_q == STREAM) && (cnt_q < HIGH_CNT);
    assign out_valid = (cnt_q >= OUT_CNT) || ((state_q == DRAIN) && (cnt_q != '0));
    assign out_data  = buf_q[OUT_BITS-1:0];
    assign out_last  = out_valid && (state_q == DRAIN) && (cnt_q <= OUT_CNT);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        in_masked = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            in_masked[i*8 +: 8] = (i < int'(in_nbytes)) ? in_bytes[i] : 8'h00;
        end
    end

    always_comb begin
        take = '0;
        if (out_fire) begin
            take = (cnt_q < OUT_CNT) ? cnt_q : OUT_CNT;
        end
        cnt_kept = cnt_q - take;
        buf_kept = buf_q >> take;
        in_bits  = CNT_W'({in_nbytes, 3'b000});
        append   = BUF_W'(in_masked) << cnt_kept;
    end

    always_comb begin
        buf_d   = buf_kept;
        cnt_d   = cnt_kept;
        state_d = state_q;
        if (in_fire) begin
            buf_d = buf_kept | append;
            cnt_d = cnt_kept + in_bits;
            if (in_last) begin
                state_d = DRAIN;
            end
        end
        // The last word empties the buffer; in_fire cannot coincide since DRAIN blocks input.
        if (out_fire && out_last) begin
            state_d = STREAM;
            cnt_d   = '0;
            buf_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            state_q <= STREAM;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_bytes2bits_gearbox.sv
// Directed and randomised checks of bytes2bits_gearbox against hand values and a bit-queue model.
`timescale 1ns/1ps
module tb_bytes2bits_gearbox;
    import conv_pkg::*;

    localparam int IN_BYTES = 4;
    localparam int OUT_BITS = 12;
    localparam int BUF_W    = buf_w(IN_BYTES, OUT_BITS);

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [32:0] word_q_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                     in_valid, in_ready, in_last;
    logic                     out_valid, out_ready, out_last;
    logic [IN_BYTES-1:0][7:0] in_bytes;
    logic [2:0]               in_nbytes;
    logic [OUT_BITS-1:0]      out_data;

    int      n_checks = 0;
    int      n_fail   = 0;
    word_q_t exp_q;
    bit      sweep_go = 1'b0;

    bytes2bits_gearbox #(.IN_BYTES(IN_BYTES), .OUT_BITS(OUT_BITS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_bytes(in_bytes),
        .in_nbytes(in_nbytes), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    a_cnt_range: assert property (@(posedge clk) disable iff (rst) dut.cnt_q <= BUF_W);
    a_buf_zero:  assert property (@(posedge clk) disable iff (rst) (dut.buf_q >> dut.cnt_q) == '0);
    a_stall:     assert property (@(posedge clk) disable iff (rst)
                     (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));
    a_nbytes:    assert property (@(posedge clk) disable iff (rst)
                     in_valid |-> (in_nbytes >= 3'd1 && in_nbytes <= 3'(IN_BYTES)));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic word_q_t model_words(input byte_q_t bytes, input int ob);
        word_q_t     w;
        logic [31:0] d;
        int          nbits;
        nbits = bytes.size() * 8;
        for (int p = 0; p < nbits; p += ob) begin
            d = '0;
            for (int j = 0; j < ob; j++) begin
                if (p + j < nbits) d[j] = bytes[(p + j) / 8][(p + j) % 8];
            end
            w.push_back({(p + ob >= nbits), d});
        end
        return w;
    endfunction

    task automatic push_exp(input logic [31:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    task automatic send_beat(input logic [31:0] b, input int nb, input logic last);
        int budget;
        in_valid  = 1'b1;
        in_bytes  = b;
        in_nbytes = 3'(nb);
        in_last   = last;
        budget    = 0;
        @(negedge clk);
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [32:0] mon_e;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(out_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("word_data", 64'(out_data), 64'(mon_e[31:0]));
                check("word_last", 64'(out_last), 64'(mon_e[32]));
            end
        end
    end

    genvar g;
    for (g = 0; g < 3; g++) begin : g_sweep
        localparam int OB = (g == 0) ? 1 : (g == 1) ? 8 : 13;

        logic                     s_in_valid, s_in_ready, s_in_last;
        logic                     s_out_valid, s_out_ready, s_out_last;
        logic [IN_BYTES-1:0][7:0] s_in_bytes;
        logic [2:0]               s_in_nbytes;
        logic [OB-1:0]            s_out_data;
        word_q_t                  s_exp;
        logic [32:0]              s_e;
        bit                       s_done = 1'b0;

        bytes2bits_gearbox #(.IN_BYTES(IN_BYTES), .OUT_BITS(OB)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(s_in_valid), .in_ready(s_in_ready), .in_bytes(s_in_bytes),
            .in_nbytes(s_in_nbytes), .in_last(s_in_last),
            .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
            .out_last(s_out_last)
        );

        always @(negedge clk) begin
            if (!rst && s_out_valid && s_out_ready) begin
                if (s_exp.size() == 0) begin
                    check($sformatf("sweep%0d_unexpected", OB), 64'(s_out_valid), 64'd0);
                end else begin
                    s_e = s_exp.pop_front();
                    check($sformatf("sweep%0d_data", OB), 64'(s_out_data), 64'(s_e[31:0]));
                    check($sformatf("sweep%0d_last", OB), 64'(s_out_last), 64'(s_e[32]));
                end
            end
        end

        always @(posedge clk) begin
            #1;
            if (sweep_go) s_out_ready = ($urandom_range(0, 3) != 0);
        end

        initial begin
            byte_q_t     bq;
            word_q_t     w;
            logic [31:0] beats[5];
            int          nbs[5];
            int          nbeats;
            int          budget;
            s_in_valid  = 1'b0;
            s_in_bytes  = '0;
            s_in_nbytes = 3'd4;
            s_in_last   = 1'b0;
            s_out_ready = 1'b0;
            wait (sweep_go);
            @(posedge clk);
            #1;
            for (int s = 0; s < 4; s++) begin
                bq.delete();
                nbeats = $urandom_range(1, 5);
                for (int b = 0; b < nbeats; b++) begin
                    beats[b] = $urandom;
                    nbs[b]   = $urandom_range(1, 4);
                    for (int i = 0; i < nbs[b]; i++) bq.push_back(beats[b][8*i +: 8]);
                end
                w = model_words(bq, OB);
                foreach (w[i]) s_exp.push_back(w[i]);
                for (int b = 0; b < nbeats; b++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    s_in_valid  = 1'b1;
                    s_in_bytes  = beats[b];
                    s_in_nbytes = 3'(nbs[b]);
                    s_in_last   = (b == nbeats - 1);
                    budget      = 0;
                    @(negedge clk);
                    while (!s_in_ready && budget < 400) begin
                        @(negedge clk);
                        budget++;
                    end
                    if (!s_in_ready) check($sformatf("sweep%0d_in_timeout", OB), 64'(s_in_ready), 64'd1);
                    @(posedge clk);
                    #1;
                    s_in_valid = 1'b0;
                    s_in_last  = 1'b0;
                end
                budget = 0;
                while (s_exp.size() != 0 && budget < 2000) begin
                    @(negedge clk);
                    budget++;
                end
                check($sformatf("sweep%0d_drained", OB), 64'(s_exp.size()), 64'd0);
                @(posedge clk);
                #1;
            end
            s_done = 1'b1;
        end
    end

    initial begin
        byte_q_t     bq;
        word_q_t     w;
        logic [31:0] bp_beats[4];
        int          bp_nb[4];
        int          budget;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bytes  = '0;
        in_nbytes = 3'd4;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single beat EF,CD,AB,89
        push_exp(32'hDEF, 1'b0);
        push_exp(32'hABC, 1'b0);
        push_exp(32'h089, 1'b1);
        send_beat(32'h89AB_CDEF, 4, 1'b1);
        check("latency_out_valid", 64'(out_valid), 64'd1);
        check("drain_in_ready", 64'(in_ready), 64'd0);
        wait_drain("single");
        check("b2b_in_ready", 64'(in_ready), 64'd1);

        // Exact fit: bytes 00..0B, 96 bits, 8 words
        push_exp(32'h100, 1'b0); push_exp(32'h020, 1'b0);
        push_exp(32'h403, 1'b0); push_exp(32'h050, 1'b0);
        push_exp(32'h706, 1'b0); push_exp(32'h080, 1'b0);
        push_exp(32'hA09, 1'b0); push_exp(32'h0B0, 1'b1);
        send_beat(32'h0302_0100, 4, 1'b0);
        send_beat(32'h0706_0504, 4, 1'b0);
        send_beat(32'h0B0A_0908, 4, 1'b1);
        wait_drain("exact");
        check("exact_no_pad", 64'(out_valid), 64'd0);

        // Backpressure across a 4-beat stream
        bp_beats = '{32'h1234_5678, 32'hCAFE_BABE, 32'h0F1E_2D3C, 32'hA5A5_5A5A};
        bp_nb    = '{4, 4, 4, 3};
        bq.delete();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < bp_nb[b]; i++) bq.push_back(bp_beats[b][8*i +: 8]);
        end
        w = model_words(bq, OUT_BITS);
        foreach (w[i]) exp_q.push_back(w[i]);
        out_ready = 1'b0;
        send_beat(bp_beats[0], bp_nb[0], 1'b0);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_stall_valid", 64'(out_valid), 64'd1);
            check("bp_stall_data", 64'(out_data), 64'(exp_q[0][11:0]));
            check("bp_stall_last", 64'(out_last), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int b = 1; b < 4; b++) send_beat(bp_beats[b], bp_nb[b], (b == 3));
        wait_drain("bp");

        // Partial last beat: only byte 0 is valid
        push_exp(32'h0FF, 1'b1);
        send_beat(32'hAAAA_AAFF, 1, 1'b1);
        wait_drain("partial");
        check("partial_idle", 64'(out_valid), 64'd0);

        // Reset while 20 bits are buffered
        push_exp(32'hDEF, 1'b0);
        send_beat(32'h89AB_CDEF, 4, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_cnt", 64'(dut.cnt_q), 64'd20);
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_exp_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        push_exp(32'hDEF, 1'b0);
        push_exp(32'hABC, 1'b0);
        push_exp(32'h089, 1'b1);
        send_beat(32'h89AB_CDEF, 4, 1'b1);
        wait_drain("post_rst");
        check("post_rst_idle", 64'(out_valid), 64'd0);

        // Parameter sweep on random streams
        sweep_go = 1'b1;
        budget   = 0;
        while (!(g_sweep[0].s_done && g_sweep[1].s_done && g_sweep[2].s_done) && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        check("sweep_complete", 64'({g_sweep[2].s_done, g_sweep[1].s_done, g_sweep[0].s_done}), 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
